pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control block for the pipelined CPU. It replaces the hard-wired always-enabled valid bits and register enables.
- Tracks per-stage valid and destination-register state, and detects RAW hazards between decode (stage 1) and older stages.
- Generates per-stage load enables, bubbles, branch-redirect flushes and external-memory freezes.
- Sits beside the datapath: consumes decoded fields from the rf_read IR; drives the PC, IR, operand and valid-bit register enables.

Parameters:
STAGES, 4, pipeline depth including fetch (stage 0) and writeback (stage STAGES-1); legal minimum 3.
REG_ADDR_W, 3, register-file address width.
CNT_W, 16, width of the saturating performance counters.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears state).
fetch_valid_i  in  1  fetch stage presents an instruction this cycle.
dec_src_a_i  in  REG_ADDR_W  source A register of the instruction in stage 1.
dec_use_a_i  in  1  instruction in stage 1 reads source A.
dec_src_b_i  in  REG_ADDR_W  source B register.
dec_use_b_i  in  1  instruction in stage 1 reads source B.
dec_dst_i  in  REG_ADDR_W  destination register of the instruction in stage 1.
dec_wr_i  in  1  instruction in stage 1 writes the register file.
redirect_i  in  1  taken branch/jump in stage STAGES-1; the source holds it until pc_load_o is seen.
ext_stall_i  in  1  memory not ready; freezes the whole pipeline.
stage_valid_o  out  STAGES-1  registered valid; bit i is stage i+1.
stage_en_o  out  STAGES  bit 0 is PC increment enable; bit i is load enable of the registers feeding stage i.
pc_load_o  out  1  redirect accepted this cycle; PC loads the writeback target.
hazard_o  out  1  raw RAW hazard detected (combinational).
fwd_a_o  out  1  source A bypassed from writeback (PIPE_FWD_EN only, else 0).
fwd_b_o  out  1  as fwd_a_o, for source B.
stall_cnt_o  out  CNT_W  cycles with a hazard bubble applied.
flush_cnt_o  out  CNT_W  redirects accepted.

Behaviour:
- State per stage k=1..STAGES-1: v[k], dst[k], wr[k].
- Reset (reset==0 at an edge) clears:
  - all v, wr, dst;
  - stall_cnt_o and flush_cnt_o.
- Reset is a synchronous clear with highest priority, including mid-stall and mid-redirect.
- Combinational outputs are don't-care while reset is low.
- The cycle after reset releases: stage_valid_o=0, pc_load_o=0, hazard_o=0, stage_en_o all 1 (assuming ext_stall_i low).
- match(r) = OR over j=2..STAGES-1 of (v[j] & wr[j] & dst[j]==r).
- hazard_o = v[1] & ((dec_use_a_i & match(src_a)) | (dec_use_b_i & match(src_b))).
  - The RF has no write-through, so the writeback stage counts.
- Per-cycle mode, one of four, in priority order:
  1. FREEZE when ext_stall_i:
     - stage_en_o=0 and pc_load_o=0.
     - All state and counters hold; redirect_i and hazards are ignored.
  2. FLUSH when redirect_i:
     - pc_load_o=1 and stage_en_o all 1.
     - Next: all v <= 0; flush_cnt +1.
     - A coincident hazard is discarded, and stall_cnt is not incremented.
  3. BUBBLE when hazard_o:
     - stage_en_o[0]=0 and stage_en_o[1]=0; stages 0 and 1 hold.
     - Stage 2 gets v[2]<=0.
     - Stages k>=3 take stage k-1 state; stall_cnt +1.
  4. ADVANCE otherwise:
     - stage_en_o all 1.
     - v[1]<=fetch_valid_i, dst[1]<=dec_dst_i, wr[1]<=dec_wr_i.
     - Stage k takes stage k-1 state.
- In BUBBLE and ADVANCE, stage 2 loads dst[2]<=dec_dst_i and wr[2]<=dec_wr_i. This captures decode fields at the stage-1→2 transfer; fields in stage 1 are taken from the decode inputs.
- Hazard latency:
  - Producer in stage 2 with no forwarding: STAGES-2 bubbles.
  - Each bubble moves the producer one stage older.
- Counters saturate at 2^CNT_W-1; no wrap.
- pc_load_o is asserted exactly one cycle per accepted redirect.

Optional Feature:
Macro: PIPE_FWD_EN.
- Defined:
  - match() for stall purposes covers only j=2..STAGES-2.
  - fwd_a_o = v[1] & dec_use_a_i & v[STAGES-1] & wr[STAGES-1] & dst[STAGES-1]==src_a, and no match among j=2..STAGES-2. fwd_b_o likewise for source B.
  - The datapath muxes writeback data into the operand register.
  - The writeback-stage hazard costs 0 bubbles.
- Undefined:
  - fwd_a_o and fwd_b_o are tied 0.
  - The stall set includes the writeback stage, as in Behaviour.

Test Plan (STAGES=4, REG_ADDR_W=3):
1. Hold reset=0 for 2 cycles, then release with fetch_valid_i=1 and no uses → stage_valid_o 000, then 001, 011, 111 on successive cycles; stage_en_o=1111 throughout; counters 0.
2. Stage-1 instruction dec_dst_i=3, dec_wr_i=1 advances; next stage-1 instruction uses src_a=3 → without PIPE_FWD_EN: hazard_o=1 for 2 cycles, stage_en_o=1100 both cycles, stall_cnt_o=2. With the macro: 1 bubble, then fwd_a_o=1 for one cycle, stall_cnt_o=1.
3. Pipeline full (111), redirect_i=1 for one cycle → pc_load_o=1 that cycle; next cycle stage_valid_o=000; flush_cnt_o=1.
4. Hazard pending, then redirect_i=1 and ext_stall_i=1 together for 3 cycles → stage_en_o=0000, pc_load_o=0, state and counters unchanged. On the cycle ext_stall_i drops: pc_load_o=1, flush_cnt_o=1, stall_cnt_o unchanged.
5. reset=0 asserted during a bubble cycle with stall_cnt_o=1 → next cycle stage_valid_o=000, stall_cnt_o=0, hazard_o=0.
6. With CNT_W=2, force 5 consecutive hazard bubbles → stall_cnt_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of control/decode signals between the datapath and the pipeline
// hazard controller. The datapath side uses the master modport, the
// controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int STAGES     = 4,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  fetch_valid_i;
    logic [REG_ADDR_W-1:0] dec_src_a_i;
    logic                  dec_use_a_i;
    logic [REG_ADDR_W-1:0] dec_src_b_i;
    logic                  dec_use_b_i;
    logic [REG_ADDR_W-1:0] dec_dst_i;
    logic                  dec_wr_i;
    logic                  redirect_i;
    logic                  ext_stall_i;
    logic [STAGES-2:0]     stage_valid_o;
    logic [STAGES-1:0]     stage_en_o;
    logic                  pc_load_o;
    logic                  hazard_o;
    logic                  fwd_a_o;
    logic                  fwd_b_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output fetch_valid_i, dec_src_a_i, dec_use_a_i, dec_src_b_i,
               dec_use_b_i, dec_dst_i, dec_wr_i, redirect_i, ext_stall_i,
        input  stage_valid_o, stage_en_o, pc_load_o, hazard_o, fwd_a_o,
               fwd_b_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  fetch_valid_i, dec_src_a_i, dec_use_a_i, dec_src_b_i,
               dec_use_b_i, dec_dst_i, dec_wr_i, redirect_i, ext_stall_i,
        output stage_valid_o, stage_en_o, pc_load_o, hazard_o, fwd_a_o,
               fwd_b_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: per-stage valid/destination tracking, RAW hazard
// detection against older stages, bubble insertion, redirect flush and
// external-memory freeze, plus saturating stall/flush counters.
// Optional macro PIPE_FWD_EN: writeback-stage producers are bypassed
// (fwd_a_o/fwd_b_o) instead of stalling.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 4,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                reset,
    pipe_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        M_ADVANCE,
        M_BUBBLE,
        M_FLUSH,
        M_FREEZE
    } mode_t;

`ifdef PIPE_FWD_EN
    // The writeback stage is bypassed, so it never causes a stall.
    localparam int STALL_TOP = STAGES - 2;
`else
    // No RF write-through: the writeback stage still has to drain.
    localparam int STALL_TOP = STAGES - 1;
`endif

    logic [STAGES-1:1]     v;
    logic                  wr  [1:STAGES-1];
    logic [REG_ADDR_W-1:0] dst [1:STAGES-1];

    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    logic                  match_a;
    logic                  match_b;
    logic                  hazard;
    mode_t                 mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Compare decode sources against every older in-flight producer.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int j = 2; j <= STALL_TOP; j++) begin
            if (v[j] && wr[j] && (dst[j] == bus.dec_src_a_i)) match_a = 1'b1;
            if (v[j] && wr[j] && (dst[j] == bus.dec_src_b_i)) match_b = 1'b1;
        end
        hazard = v[1] & ((bus.dec_use_a_i & match_a) | (bus.dec_use_b_i & match_b));
    end

    // Select the cycle mode by priority and derive the register enables.
    always_comb begin
        mode          = M_ADVANCE;
        bus.stage_en_o = '1;
        bus.pc_load_o  = 1'b0;
        if (bus.ext_stall_i) begin
            mode           = M_FREEZE;
            bus.stage_en_o = '0;
        end else if (bus.redirect_i) begin
            mode          = M_FLUSH;
            bus.pc_load_o = 1'b1;
        end else if (hazard) begin
            mode              = M_BUBBLE;
            bus.stage_en_o[0] = 1'b0;
            bus.stage_en_o[1] = 1'b0;
        end
    end

    // Advance, bubble or clear the per-stage tracking state and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v         <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            for (int k = 1; k <= STAGES - 1; k++) begin
                wr[k]  <= 1'b0;
                dst[k] <= '0;
            end
        end else begin
            case (mode)
                M_FREEZE: ;
                M_FLUSH: begin
                    v         <= '0;
                    flush_cnt <= sat_inc(flush_cnt);
                end
                M_BUBBLE, M_ADVANCE: begin
                    // Stage-2 fields come straight from decode at the 1->2 transfer.
                    dst[2] <= bus.dec_dst_i;
                    wr[2]  <= bus.dec_wr_i;
                    for (int k = 3; k <= STAGES - 1; k++) begin
                        v[k]   <= v[k-1];
                        wr[k]  <= wr[k-1];
                        dst[k] <= dst[k-1];
                    end
                    if (mode == M_BUBBLE) begin
                        v[2]      <= 1'b0;
                        stall_cnt <= sat_inc(stall_cnt);
                    end else begin
                        v[1]   <= bus.fetch_valid_i;
                        wr[1]  <= bus.dec_wr_i;
                        dst[1] <= bus.dec_dst_i;
                        v[2]   <= v[1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stage_valid_o = v;
    assign bus.hazard_o      = hazard;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;

`ifdef PIPE_FWD_EN
    assign bus.fwd_a_o = v[1] & bus.dec_use_a_i & v[STAGES-1] & wr[STAGES-1]
                         & (dst[STAGES-1] == bus.dec_src_a_i) & ~match_a;
    assign bus.fwd_b_o = v[1] & bus.dec_use_b_i & v[STAGES-1] & wr[STAGES-1]
                         & (dst[STAGES-1] == bus.dec_src_b_i) & ~match_b;
`else
    assign bus.fwd_a_o = 1'b0;
    assign bus.fwd_b_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a STAGES=4 instance for the main
// scenarios and a STAGES=7, CNT_W=2 instance for counter saturation.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef PIPE_FWD_EN
    localparam int SB = 1;  // stall count after the first hazard scenario
`else
    localparam int SB = 2;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.STAGES(4), .REG_ADDR_W(3), .CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.STAGES(7), .REG_ADDR_W(3), .CNT_W(2))  bus2 ();

    pipe_hazard_ctrl #(.STAGES(4), .REG_ADDR_W(3), .CNT_W(16)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipe_hazard_ctrl #(.STAGES(7), .REG_ADDR_W(3), .CNT_W(2)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b0;
        bus.fetch_valid_i  = 1'b0;
        bus.dec_src_a_i    = '0;
        bus.dec_use_a_i    = 1'b0;
        bus.dec_src_b_i    = '0;
        bus.dec_use_b_i    = 1'b0;
        bus.dec_dst_i      = '0;
        bus.dec_wr_i       = 1'b0;
        bus.redirect_i     = 1'b0;
        bus.ext_stall_i    = 1'b0;
        bus2.fetch_valid_i = 1'b0;
        bus2.dec_src_a_i   = '0;
        bus2.dec_use_a_i   = 1'b0;
        bus2.dec_src_b_i   = '0;
        bus2.dec_use_b_i   = 1'b0;
        bus2.dec_dst_i     = '0;
        bus2.dec_wr_i      = 1'b0;
        bus2.redirect_i    = 1'b0;
        bus2.ext_stall_i   = 1'b0;

        // 1: reset release and fill
        tick();
        tick();
        reset = 1'b1;
        bus.fetch_valid_i = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.stage_valid_o), 32'h0);
        chk("rst_en", 32'(bus.stage_en_o), 32'hF);
        chk("rst_pcload", 32'(bus.pc_load_o), 32'h0);
        chk("rst_hazard", 32'(bus.hazard_o), 32'h0);
        chk("rst_stall", 32'(bus.stall_cnt_o), 32'h0);
        chk("rst_flush", 32'(bus.flush_cnt_o), 32'h0);
        tick();
        chk("fill1_valid", 32'(bus.stage_valid_o), 32'h1);
        chk("fill1_en", 32'(bus.stage_en_o), 32'hF);
        tick();
        chk("fill2_valid", 32'(bus.stage_valid_o), 32'h3);
        tick();
        chk("fill3_valid", 32'(bus.stage_valid_o), 32'h7);
        chk("fill3_en", 32'(bus.stage_en_o), 32'hF);
        chk("fill3_stall", 32'(bus.stall_cnt_o), 32'h0);

        // 2: producer r3 then consumer of r3 via source A
        bus.dec_dst_i = 3'd3;
        bus.dec_wr_i  = 1'b1;
        #1;
        chk("prod_hazard", 32'(bus.hazard_o), 32'h0);
        tick();
        bus.dec_dst_i   = 3'd0;
        bus.dec_wr_i    = 1'b0;
        bus.dec_use_a_i = 1'b1;
        bus.dec_src_a_i = 3'd3;
        #1;
        chk("raw0_hazard", 32'(bus.hazard_o), 32'h1);
        chk("raw0_en", 32'(bus.stage_en_o), 32'hC);
        chk("raw0_valid", 32'(bus.stage_valid_o), 32'h7);
        tick();
`ifdef PIPE_FWD_EN
        chk("raw1_hazard", 32'(bus.hazard_o), 32'h0);
        chk("raw1_fwd_a", 32'(bus.fwd_a_o), 32'h1);
        chk("raw1_en", 32'(bus.stage_en_o), 32'hF);
`else
        chk("raw1_hazard", 32'(bus.hazard_o), 32'h1);
        chk("raw1_fwd_a", 32'(bus.fwd_a_o), 32'h0);
        chk("raw1_en", 32'(bus.stage_en_o), 32'hC);
`endif
        chk("raw1_valid", 32'(bus.stage_valid_o), 32'h5);
        chk("raw1_stall", 32'(bus.stall_cnt_o), 32'h1);
        tick();
        chk("raw2_hazard", 32'(bus.hazard_o), 32'h0);
        chk("raw2_fwd_a", 32'(bus.fwd_a_o), 32'h0);
        chk("raw2_en", 32'(bus.stage_en_o), 32'hF);
        chk("raw2_stall", 32'(bus.stall_cnt_o), 32'(SB));
`ifdef PIPE_FWD_EN
        chk("raw2_valid", 32'(bus.stage_valid_o), 32'h3);
`else
        chk("raw2_valid", 32'(bus.stage_valid_o), 32'h1);
`endif
        bus.dec_use_a_i = 1'b0;
        tick();
        tick();
        chk("refill_valid", 32'(bus.stage_valid_o), 32'h7);

        // 3: redirect with a full pipeline
        bus.redirect_i = 1'b1;
        #1;
        chk("redir_pcload", 32'(bus.pc_load_o), 32'h1);
        chk("redir_en", 32'(bus.stage_en_o), 32'hF);
        tick();
        bus.redirect_i = 1'b0;
        #1;
        chk("flush_valid", 32'(bus.stage_valid_o), 32'h0);
        chk("flush_cnt", 32'(bus.flush_cnt_o), 32'h1);
        chk("flush_pcload", 32'(bus.pc_load_o), 32'h0);

        // 4: hazard pending, then redirect under an external freeze
        tick();
        bus.dec_dst_i = 3'd5;
        bus.dec_wr_i  = 1'b1;
        tick();
        bus.dec_dst_i   = 3'd0;
        bus.dec_wr_i    = 1'b0;
        bus.dec_use_b_i = 1'b1;
        bus.dec_src_b_i = 3'd5;
        #1;
        chk("pend_hazard", 32'(bus.hazard_o), 32'h1);
        bus.redirect_i  = 1'b1;
        bus.ext_stall_i = 1'b1;
        #1;
        chk("frz_en", 32'(bus.stage_en_o), 32'h0);
        chk("frz_pcload", 32'(bus.pc_load_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_valid", 32'(bus.stage_valid_o), 32'h3);
            chk("frz_stall", 32'(bus.stall_cnt_o), 32'(SB));
            chk("frz_flush", 32'(bus.flush_cnt_o), 32'h1);
            chk("frz_en_hold", 32'(bus.stage_en_o), 32'h0);
            chk("frz_pc_hold", 32'(bus.pc_load_o), 32'h0);
        end
        bus.ext_stall_i = 1'b0;
        #1;
        chk("unfrz_pcload", 32'(bus.pc_load_o), 32'h1);
        chk("unfrz_en", 32'(bus.stage_en_o), 32'hF);
        tick();
        bus.redirect_i  = 1'b0;
        bus.dec_use_b_i = 1'b0;
        #1;
        chk("unfrz_valid", 32'(bus.stage_valid_o), 32'h0);
        chk("unfrz_flush", 32'(bus.flush_cnt_o), 32'h2);
        chk("unfrz_stall", 32'(bus.stall_cnt_o), 32'(SB));
        chk("unfrz_pc_once", 32'(bus.pc_load_o), 32'h0);

        // 5: reset asserted in a bubble cycle
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("r5_valid0", 32'(bus.stage_valid_o), 32'h0);
        tick();
        bus.dec_dst_i = 3'd2;
        bus.dec_wr_i  = 1'b1;
        tick();
        bus.dec_dst_i   = 3'd0;
        bus.dec_wr_i    = 1'b0;
        bus.dec_use_a_i = 1'b1;
        bus.dec_src_a_i = 3'd2;
        #1;
        chk("r5_hazard", 32'(bus.hazard_o), 32'h1);
        tick();
        chk("r5_stall1", 32'(bus.stall_cnt_o), 32'h1);
`ifdef PIPE_FWD_EN
        chk("r5_hazard2", 32'(bus.hazard_o), 32'h0);
`else
        chk("r5_hazard2", 32'(bus.hazard_o), 32'h1);
`endif
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("r5_valid", 32'(bus.stage_valid_o), 32'h0);
        chk("r5_stall", 32'(bus.stall_cnt_o), 32'h0);
        chk("r5_flush", 32'(bus.flush_cnt_o), 32'h0);
        chk("r5_hazard_clr", 32'(bus.hazard_o), 32'h0);
        bus.dec_use_a_i = 1'b0;

        // 6: counter saturation on the deep, narrow-counter instance
        bus2.fetch_valid_i = 1'b1;
        bus2.dec_dst_i     = 3'd1;
        bus2.dec_wr_i      = 1'b1;
        tick();
        tick();
        bus2.dec_dst_i   = 3'd0;
        bus2.dec_wr_i    = 1'b0;
        bus2.dec_use_a_i = 1'b1;
        bus2.dec_src_a_i = 3'd1;
        #1;
        chk("sat_hazard", 32'(bus2.hazard_o), 32'h1);
        chk("sat_stall0", 32'(bus2.stall_cnt_o), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_stall", 32'(bus2.stall_cnt_o), 32'((i > 3) ? 3 : i));
        end
        chk("sat_hazard_end", 32'(bus2.hazard_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
